serial_in_buffer: RTL and testbench

- Receive-side counterpart of the serial out buffer. It consumes the serial data line and the serial clock line that the transmitter produces.
- It rebuilds each 15-bit frame (7-bit address, then 8-bit data) and presents the (A, D) pair on a valid/ready parallel interface.
- It runs entirely in the clk_in domain. The serial clock is treated as a data signal and is oversampled, never used as a clock.

---
 rtl/sib_pkg.sv | 20 ++
 rtl/sib_sync.sv | 44 ++++
 rtl/serial_in_buffer.sv | 134 +++++++++++++
 tb/tb_serial_in_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sib_pkg.sv
// Shared definitions for the serial link: default field widths, frame layout
// and receiver state encoding. The frame constants are also used by the transmitter.
package sib_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int FRAME_LEN  = DEF_ADDR_W + DEF_DATA_W;

    // Bit positions within a frame as it sits in the receive shift register.
    localparam int ADDR_MSB = FRAME_LEN - 1;
    localparam int ADDR_LSB = DEF_DATA_W;
    localparam int DATA_MSB = DEF_DATA_W - 1;
    localparam int DATA_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sib_state_t;

endpackage

// File: rtl/sib_sync.sv
// Multi-flop synchroniser for one asynchronous input, with an optional
// rising-edge pulse taken from the synchronised level.
module sib_sync #(
    parameter int STAGES   = 2,
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic prev;

            always_ff @(posedge clk_in or negedge reset_n) begin
                if (!reset_n) begin
                    prev <= 1'b0;
                end else begin
                    prev <= sync_out;
                end
            end

            assign rise = sync_out & ~prev;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serial_in_buffer.sv
// Serial frame receiver: oversamples InC/InD, rebuilds (A, D) frames and offers
// them on a valid/ready port. Define SIB_TIMEOUT_EN to drop stalled partial frames.
module serial_in_buffer
    import sib_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              InD,
    input  logic              InC,
    input  logic              Ready,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              Valid,
    output logic              Overrun,
    output logic              Busy
);

    localparam int FRM_LEN = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRM_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRM_LEN - 1);

    logic               c_rise;
    logic               c_level_unused;
    logic               d_sync;
    logic               d_rise_unused;
    logic [FRM_LEN-1:0] shift_q;
    logic [FRM_LEN-1:0] frame_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic               valid_q;
    logic               overrun_q;
    sib_state_t         state;

    sib_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_c (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .async_in (InC),
        .sync_out (c_level_unused),
        .rise     (c_rise)
    );

    sib_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_d (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .async_in (InD),
        .sync_out (d_sync),
        .rise     (d_rise_unused)
    );

    assign frame_next = {shift_q[FRM_LEN-2:0], d_sync};

`ifdef SIB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

    // A completed frame only overwrites A/D when the old one is gone or being taken now.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            A         <= '0;
            D         <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && Ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (c_rise) begin
                        shift_q <= {{(FRM_LEN-1){1'b0}}, d_sync};
                        bit_cnt <= CNT_W'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (c_rise) begin
                        shift_q <= frame_next;
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            if (!valid_q || Ready) begin
                                A       <= frame_next[FRM_LEN-1:DATA_W];
                                D       <= frame_next[DATA_W-1:0];
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef SIB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        shift_q <= '0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase

`ifdef SIB_TIMEOUT_EN
            if (state == SHIFT && !c_rise && to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

    assign Valid   = valid_q;
    assign Overrun = overrun_q;
    assign Busy    = (state == SHIFT);

endmodule

// File: tb/tb_serial_in_buffer.sv
// Scoreboard bench for serial_in_buffer: directed frames are queued as expected
// results and a monitor compares every frame the DUT presents.
module tb_serial_in_buffer;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int FRM_LEN  = ADDR_W + DATA_W;
    localparam int TIMEOUT  = 64;
    localparam int HALF_BIT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } frame_t;

    logic              clk_in  = 1'b0;
    logic              reset_n = 1'b0;
    logic              InD     = 1'b0;
    logic              InC     = 1'b0;
    logic              Ready   = 1'b0;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D;
    logic              Valid;
    logic              Overrun;
    logic              Busy;

    frame_t exp_q[$];
    frame_t held;
    int     checks_total   = 0;
    int     checks_passed  = 0;
    int     overrun_cycles = 0;
    int     ov_start;
    logic   prev_valid     = 1'b0;

    serial_in_buffer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .InD     (InD),
        .InC     (InC),
        .Ready   (Ready),
        .A       (A),
        .D       (D),
        .Valid   (Valid),
        .Overrun (Overrun),
        .Busy    (Busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b, input bit pulse_ready);
        InD = b;
        wait_neg(HALF_BIT);
        InC = 1'b1;
        if (pulse_ready) begin
            // Two synchroniser flops plus the edge detector put completion on the third edge.
            wait_neg(2);
            Ready = 1'b1;
            wait_neg(1);
            Ready = 1'b0;
            wait_neg(HALF_BIT - 3);
        end else begin
            wait_neg(HALF_BIT);
        end
        InC = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                  input int nbits, input bit pulse_last);
        logic [FRM_LEN-1:0] bits;
        bits = {addr, data};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[FRM_LEN-1-i], pulse_last && (i == FRM_LEN - 1));
            if (i < FRM_LEN - 1) begin
                check_output("busy mid-frame", 32'(Busy), 32'd1);
            end else begin
                check_output("busy after frame", 32'(Busy), 32'd0);
            end
        end
    endtask

    // A frame is newly presented when Valid rises or stays high across a consuming edge.
    initial begin
        frame_t f;
        forever begin
            @(posedge clk_in);
            #1;
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (Overrun) begin
                    overrun_cycles++;
                end
                if (Valid && (!prev_valid || Ready)) begin
                    check_output("pending frame", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        f = exp_q.pop_front();
                        check_output("frame A", 32'(A), 32'(f.a));
                        check_output("frame D", 32'(D), 32'(f.d));
                        held = f;
                    end
                end else if (Valid) begin
                    check_output("held A", 32'(A), 32'(held.a));
                    check_output("held D", 32'(D), 32'(held.d));
                end
                prev_valid = Valid;
            end
        end
    end

    initial begin
        #8;
        check_output("reset A", 32'(A), 32'd0);
        check_output("reset D", 32'(D), 32'd0);
        check_output("reset Valid", 32'(Valid), 32'd0);
        check_output("reset Overrun", 32'(Overrun), 32'd0);
        check_output("reset Busy", 32'(Busy), 32'd0);
        @(negedge clk_in);
        reset_n = 1'b1;
        Ready   = 1'b1;
        wait_neg(3);

        // Basic frame, consumer always ready.
        ov_start = overrun_cycles;
        exp_q.push_back('{a: 7'h55, d: 8'hA3});
        apply_stimulus(7'h55, 8'hA3, FRM_LEN, 1'b0);
        wait_neg(3);
        check_output("valid drops after take", 32'(Valid), 32'd0);

        // Consumer stalled: second frame is dropped and flagged.
        Ready = 1'b0;
        exp_q.push_back('{a: 7'h7F, d: 8'hFF});
        apply_stimulus(7'h7F, 8'hFF, FRM_LEN, 1'b0);
        apply_stimulus(7'h01, 8'h02, FRM_LEN, 1'b0);
        wait_neg(3);
        check_output("overrun pulse count", 32'(overrun_cycles - ov_start), 32'd1);
        check_output("overrun keeps A", 32'(A), 32'h7F);
        check_output("overrun keeps D", 32'(D), 32'hFF);
        Ready = 1'b1;
        wait_neg(2);
        Ready = 1'b0;
        check_output("valid after drain", 32'(Valid), 32'd0);

        // Ready lands on the exact completion cycle of the second frame.
        exp_q.push_back('{a: 7'h12, d: 8'h34});
        apply_stimulus(7'h12, 8'h34, FRM_LEN, 1'b0);
        ov_start = overrun_cycles;
        exp_q.push_back('{a: 7'h56, d: 8'h78});
        apply_stimulus(7'h56, 8'h78, FRM_LEN, 1'b1);
        wait_neg(2);
        check_output("no overrun on swap", 32'(overrun_cycles - ov_start), 32'd0);
        check_output("valid held after swap", 32'(Valid), 32'd1);

        // Reset in the middle of a frame while a frame is still held.
        apply_stimulus(7'h33, 8'h44, 6, 1'b0);
        reset_n = 1'b0;
        wait_neg(2);
        check_output("mid reset A", 32'(A), 32'd0);
        check_output("mid reset D", 32'(D), 32'd0);
        check_output("mid reset Valid", 32'(Valid), 32'd0);
        check_output("mid reset Busy", 32'(Busy), 32'd0);
        check_output("mid reset Overrun", 32'(Overrun), 32'd0);
        reset_n = 1'b1;
        Ready   = 1'b1;
        wait_neg(2);
        exp_q.push_back('{a: 7'h0F, d: 8'hF0});
        apply_stimulus(7'h0F, 8'hF0, FRM_LEN, 1'b0);
        wait_neg(4);

`ifdef SIB_TIMEOUT_EN
        apply_stimulus(7'h11, 8'h22, 9, 1'b0);
        wait_neg(TIMEOUT + 5);
        check_output("busy after timeout", 32'(Busy), 32'd0);
        check_output("no valid after timeout", 32'(Valid), 32'd0);
        exp_q.push_back('{a: 7'h2A, d: 8'h5C});
        apply_stimulus(7'h2A, 8'h5C, FRM_LEN, 1'b0);
        wait_neg(4);
`endif

        // Completion depends only on InC edges; InD stays low throughout.
        exp_q.push_back('{a: 7'h00, d: 8'h00});
        apply_stimulus(7'h00, 8'h00, FRM_LEN, 1'b0);
        wait_neg(10);

        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
